seg_frame_driver: RTL and testbench
===================================

Name: seg_frame_driver

Overview:
- Downstream companion of the 8-digit anode scanner.
- Consumes the scanner's 3-bit digit select and drives the shared active-low cathode bus (7 segments plus DP) with the glyph for the selected digit.
- Holds a double-buffered 8-digit frame (hex nibbles, DP, blank and blink masks). New data is committed only at frame boundaries, so the display never tears.
- Adds anti-ghosting blanking after every digit change.

Parameters:
BLANK_CYC, 2, clk cycles cathodes are forced off after each seq_sel change (0..15; 0 disables)
FRAME_W, 6, width of frame counter; its MSB is the blink phase (toggles every 2^(FRAME_W-1) frames)

Ports:
clk  in  1  system clock; scanner state changes are synchronous to this domain
reset  in  1  asynchronous, active-high
seq_sel  in  3  digit currently enabled by the scanner (0 = rightmost)
wr_data  in  32  hex nibbles; digit k = wr_data[4k+3:4k]
wr_dp  in  8  decimal point enable per digit (1 = lit)
wr_blank  in  8  per-digit blank (1 = all segments off)
wr_blink  in  8  per-digit blink enable
wr_valid  in  1  write request
wr_ready  out  1  pending buffer empty; write is accepted when wr_valid&&wr_ready
cathode  out  7  {g,f,e,d,c,b,a}, active-low, registered
dp_n  out  1  decimal point, active-low, registered
frame_start  out  1  one-cycle pulse after each frame commit point

Behaviour:
- Reset values:
  - cathode=7'h7F, dp_n=1, frame_start=0, wr_ready=1.
  - Active frame: data=0, dp=0, blank=8'hFF, blink=0.
  - Pending buffer empty.
  - sel_q=0, ghost_cnt=0, frame_cnt=0.
- Write handshake:
  - On an accepted write, capture into the pending buffer and set pending. wr_ready=!pending (registered), so it goes low the cycle after acceptance.
  - wr_valid while wr_ready=0 is ignored. The writer holds the request.
- Frame boundary:
  - Asserted at any edge where sel_q==7 && seq_sel==0.
  - At a boundary with pending set: copy pending into the active frame, clear pending. wr_ready=1 from the next cycle.
  - frame_cnt increments at every boundary, wrapping mod 2^FRAME_W.
  - frame_start=1 for the cycle following each boundary, whether or not data was committed.
- Write and boundary in the same edge: the write goes to pending and is NOT committed at that boundary. It commits at the next boundary.
- Digit change:
  - At any edge where seq_sel!=sel_q: sel_q<=seq_sel and ghost_cnt<=BLANK_CYC.
  - Otherwise ghost_cnt decrements toward 0, saturating at 0.
  - Timing: for a change sampled at edge N, cathode=7F and dp_n=1 after edges N..N+BLANK_CYC-1. The glyph appears after edge N+BLANK_CYC. With BLANK_CYC=0 the glyph appears after edge N.
  - If seq_sel changes again before blanking expires, the counter reloads and the output stays blanked.
- Output, digit d=selected:
  - off = ghost active || blank[d] || (blink[d] && frame_cnt[FRAME_W-1]).
  - cathode = off ? 7F : hex_to_seg(data[4d+3:4d]).
  - dp_n = off ? 1 : !dp[d].
  - Output registers see the updated active frame on the edge after commit.
- Hex table, active-low {g..a}:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
- Out-of-order seq_sel (not wrapping 7→0) is legal. It only triggers ghost blanking, never a commit.
- Reset mid-operation: pending data is discarded, the active frame returns to all-blank, and outputs go to the off state immediately (asynchronous reset).

Decomposition:
- seg_pkg holds:
  - NUM_DIGITS=8
  - SEG_OFF=7'h7F
  - the 16-entry hex glyph constant table
  - the bit-order definition of {g..a}
- One combinational sub-module, hex_to_seg (4-bit nibble in → 7-bit active-low glyph out), instantiated once on the muxed nibble.

Test Plan:
- Reset, then seq_sel stepping 0..7 every 4 cycles -> cathode=7F, dp_n=1 throughout (all digits blanked), wr_ready=1, frame_start pulses once per 7→0 wrap.
- Write data=32'h76543210, blank=00, dp=01 at mid-frame -> wr_ready=0 until the next 7→0 wrap. From then on digit0 shows 40 with dp_n=0 and digit7 shows 78; wr_ready returns to 1.
- BLANK_CYC=2, seq_sel 3→4 with data nibble4=8 -> cathode 7F for 2 cycles after the change, then 00.
- Write asserted on the exact boundary edge -> old frame persists for one full frame; the new data appears only after the following wrap.
- blink=8'h01, FRAME_W=2, data nibble0=A -> digit0 alternates 08 for 2 frames, 7F for 2 frames; other digits unaffected.
- Assert reset while pending is set and glyphs are lit -> cathode=7F, dp_n=1 asynchronously. After release and one frame wrap, the display stays blank (pending was discarded).

Source files
------------

// File: rtl/seg_pkg.sv
// Shared constants and types for the 8-digit seven-segment frame driver.
// Glyphs are active-low and packed as {g,f,e,d,c,b,a}.
package seg_pkg;

  localparam int         NUM_DIGITS = 8;
  localparam logic [6:0] SEG_OFF    = 7'h7F;

  // Bit position of each segment inside a glyph word
  typedef enum int {
    SEG_A = 0,
    SEG_B = 1,
    SEG_C = 2,
    SEG_D = 3,
    SEG_E = 4,
    SEG_F = 5,
    SEG_G = 6
  } seg_bit_e;

  // Entry n is the active-low glyph for hex digit n (entry 0 is the rightmost element)
  localparam logic [15:0][6:0] HEX_GLYPH = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  typedef struct packed {
    logic [NUM_DIGITS*4-1:0] data;
    logic [NUM_DIGITS-1:0]   dp;
    logic [NUM_DIGITS-1:0]   blank;
    logic [NUM_DIGITS-1:0]   blink;
  } frame_t;

  localparam frame_t FRAME_RESET = '{
    data:  32'h0000_0000,
    dp:    8'h00,
    blank: 8'hFF,
    blink: 8'h00
  };

  function automatic logic [3:0] nibble_of(input logic [NUM_DIGITS*4-1:0] data,
                                           input logic [2:0]              digit);
    return data[{digit, 2'b00} +: 4];
  endfunction

endpackage

// File: rtl/seg_frame_driver_if.sv
// Frame write port: one full 8-digit frame per valid/ready transfer.
interface seg_frame_driver_if;
  import seg_pkg::*;

  logic [NUM_DIGITS*4-1:0] wr_data;
  logic [NUM_DIGITS-1:0]   wr_dp;
  logic [NUM_DIGITS-1:0]   wr_blank;
  logic [NUM_DIGITS-1:0]   wr_blink;
  logic                    wr_valid;
  logic                    wr_ready;

  modport master (
    output wr_data, wr_dp, wr_blank, wr_blink, wr_valid,
    input  wr_ready
  );

  modport slave (
    input  wr_data, wr_dp, wr_blank, wr_blink, wr_valid,
    output wr_ready
  );
endinterface

// File: rtl/hex_to_seg.sv
// Combinational hex nibble to active-low seven-segment glyph decoder.
module hex_to_seg
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] glyph
);

  assign glyph = HEX_GLYPH[nibble];

endmodule

// File: rtl/seg_frame_driver.sv
// Cathode driver for an 8-digit multiplexed display: double-buffered frame,
// tear-free commit on the scanner's 7->0 wrap, anti-ghost blanking on digit change.
module seg_frame_driver
  import seg_pkg::*;
#(
  parameter int BLANK_CYC = 2,
  parameter int FRAME_W   = 6
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [2:0]          seq_sel,
  seg_frame_driver_if.slave   wr,
  output logic [6:0]          cathode,
  output logic                dp_n,
  output logic                frame_start
);

  localparam logic [3:0] BLANK_LD = 4'(BLANK_CYC);

  frame_t             act_r;
  frame_t             pend_r;
  logic               pending_r;
  logic               wr_ready_r;
  logic [2:0]         sel_q_r;
  logic [3:0]         ghost_cnt_r;
  logic [FRAME_W-1:0] frame_cnt_r;
  logic [6:0]         cathode_r;
  logic               dp_n_r;
  logic               frame_start_r;

  logic               boundary_s;
  logic               accept_s;
  logic               change_s;
  logic [3:0]         ghost_nxt_s;
  logic [3:0]         nibble_s;
  logic [6:0]         glyph_s;
  logic               off_s;

  assign boundary_s = (sel_q_r == 3'd7) && (seq_sel == 3'd0);
  assign accept_s   = wr.wr_valid && wr_ready_r;
  assign change_s   = (seq_sel != sel_q_r);

  // Next blanking count: reload on any digit change, otherwise count down to zero
  always_comb begin
    ghost_nxt_s = 4'd0;
    if (change_s) begin
      ghost_nxt_s = BLANK_LD;
    end else if (ghost_cnt_r != 4'd0) begin
      ghost_nxt_s = ghost_cnt_r - 4'd1;
    end else begin
      ghost_nxt_s = 4'd0;
    end
  end

  // Output decision uses the post-edge blanking count so blanking starts on the change edge
  always_comb begin
    nibble_s = nibble_of(act_r.data, seq_sel);
    off_s    = (ghost_nxt_s != 4'd0)
            || act_r.blank[seq_sel]
            || (act_r.blink[seq_sel] && frame_cnt_r[FRAME_W-1]);
  end

  hex_to_seg u_hex_to_seg (
    .nibble (nibble_s),
    .glyph  (glyph_s)
  );

  // Pending/active frame buffers and write handshake; accept always beats commit
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      act_r      <= FRAME_RESET;
      pend_r     <= FRAME_RESET;
      pending_r  <= 1'b0;
      wr_ready_r <= 1'b1;
    end else if (accept_s) begin
      pend_r     <= '{data: wr.wr_data, dp: wr.wr_dp, blank: wr.wr_blank, blink: wr.wr_blink};
      pending_r  <= 1'b1;
      wr_ready_r <= 1'b0;
    end else if (boundary_s && pending_r) begin
      act_r      <= pend_r;
      pending_r  <= 1'b0;
      wr_ready_r <= 1'b1;
    end else begin
      pending_r  <= pending_r;
      wr_ready_r <= wr_ready_r;
    end
  end

  // Scanner tracking: last digit, blanking counter and frame counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel_q_r     <= 3'd0;
      ghost_cnt_r <= 4'd0;
      frame_cnt_r <= '0;
    end else begin
      sel_q_r     <= seq_sel;
      ghost_cnt_r <= ghost_nxt_s;
      if (boundary_s) begin
        frame_cnt_r <= frame_cnt_r + FRAME_W'(1'b1);
      end else begin
        frame_cnt_r <= frame_cnt_r;
      end
    end
  end

  // Registered cathode bus and frame pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cathode_r     <= SEG_OFF;
      dp_n_r        <= 1'b1;
      frame_start_r <= 1'b0;
    end else begin
      cathode_r     <= off_s ? SEG_OFF : glyph_s;
      dp_n_r        <= off_s ? 1'b1 : ~act_r.dp[seq_sel];
      frame_start_r <= boundary_s;
    end
  end

  assign cathode     = cathode_r;
  assign dp_n        = dp_n_r;
  assign frame_start = frame_start_r;
  assign wr.wr_ready = wr_ready_r;

endmodule

// File: tb/tb_seg_frame_driver.sv
// Directed self-checking bench for seg_frame_driver (BLANK_CYC=2, FRAME_W=2).
module tb_seg_frame_driver;
  import seg_pkg::*;

  typedef struct {
    logic [2:0] sel;
    logic [6:0] cath;
    logic       dpn;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] seq_sel;
  logic [6:0] cathode;
  logic       dp_n;
  logic       frame_start;

  seg_frame_driver_if wif ();

  seg_frame_driver #(.BLANK_CYC(2), .FRAME_W(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .seq_sel     (seq_sel),
    .wr          (wif),
    .cathode     (cathode),
    .dp_n        (dp_n),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  int   fc = 0;
  bit   pend_b = 1'b0;
  bit   exp_ready = 1'b1;
  vec_t vec [32];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock edge plus the bench's handshake/frame-counter model
  task automatic step(input bit is_wrap);
    bit acc;
    bit com;
    acc = wif.wr_valid && exp_ready;
    com = is_wrap && pend_b;
    @(posedge clk);
    #1;
    if (acc) begin
      pend_b = 1'b1;
      exp_ready = 1'b0;
    end else if (com) begin
      pend_b = 1'b0;
      exp_ready = 1'b1;
    end
    if (is_wrap) fc = (fc + 1) % 4;
    check("frame_start", frame_start, is_wrap);
    check("wr_ready", wif.wr_ready, exp_ready);
  endtask

  // Select a digit for 4 cycles: 2 ghost-blanked, then the expected glyph
  task automatic digit_check(input logic [2:0] d, input logic [6:0] cath, input logic dpn, input bit is_wrap);
    seq_sel = d;
    step(is_wrap);
    check("ghost0_cathode", cathode, 7'h7F);
    check("ghost0_dp_n", dp_n, 1'b1);
    step(1'b0);
    check("ghost1_cathode", cathode, 7'h7F);
    step(1'b0);
    check("glyph_cathode", cathode, cath);
    check("glyph_dp_n", dp_n, dpn);
    step(1'b0);
    check("glyph_hold_cathode", cathode, cath);
  endtask

  task automatic run_range(input int base, input int lo, input int hi, input bit wrap_first);
    for (int i = lo; i <= hi; i++) begin
      digit_check(vec[base+i].sel, vec[base+i].cath, vec[base+i].dpn, wrap_first && (i == 0));
    end
  endtask

  task automatic set_write(input logic [31:0] data, input logic [7:0] dp,
                           input logic [7:0] blank, input logic [7:0] blink);
    wif.wr_data  = data;
    wif.wr_dp    = dp;
    wif.wr_blank = blank;
    wif.wr_blink = blink;
    wif.wr_valid = 1'b1;
  endtask

  initial begin
    logic [6:0] ga [8];
    logic [6:0] gb [8];
    logic [6:0] exp0;
    ga = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78};
    gb = '{7'h10, 7'h03, 7'h08, 7'h0E, 7'h00, 7'h06, 7'h21, 7'h46};
    for (int i = 0; i < 8; i++) begin
      vec[i]      = '{sel: 3'(i), cath: 7'h7F, dpn: 1'b1};
      vec[8+i]    = '{sel: 3'(i), cath: ga[i], dpn: (i == 0) ? 1'b0 : 1'b1};
      vec[16+i]   = '{sel: 3'(i), cath: gb[i], dpn: (i == 7) ? 1'b0 : 1'b1};
      vec[24+i]   = '{sel: 3'(i), cath: (i == 0) ? 7'h08 : 7'h40, dpn: 1'b1};
    end

    reset = 1'b1;
    seq_sel = 3'd0;
    wif.wr_valid = 1'b0;
    wif.wr_data = 32'h0;
    wif.wr_dp = 8'h00;
    wif.wr_blank = 8'h00;
    wif.wr_blink = 8'h00;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    check("reset_cathode", cathode, 7'h7F);
    check("reset_dp_n", dp_n, 1'b1);
    check("reset_frame_start", frame_start, 1'b0);
    check("reset_wr_ready", wif.wr_ready, 1'b1);
    reset = 1'b0;

    // Blank frame, then a wrap with a write landing mid-frame
    run_range(0, 0, 7, 1'b0);
    run_range(0, 0, 3, 1'b1);
    set_write(32'h7654_3210, 8'h01, 8'h00, 8'h00);
    run_range(0, 4, 7, 1'b0);
    wif.wr_valid = 1'b0;
    run_range(8, 0, 7, 1'b1);

    // Write on the exact boundary edge: old frame stays for a full frame
    set_write(32'hCDE8_FAB9, 8'h80, 8'h00, 8'h00);
    digit_check(3'd0, 7'h40, 1'b0, 1'b1);
    wif.wr_valid = 1'b0;
    run_range(8, 1, 7, 1'b0);
    run_range(16, 0, 7, 1'b1);

    // Blink on digit 0, queued at a boundary
    set_write(32'h0000_000A, 8'h00, 8'h00, 8'h01);
    run_range(16, 0, 7, 1'b1);
    wif.wr_valid = 1'b0;
    for (int f = 0; f < 5; f++) begin
      exp0 = (((fc + 1) % 4) >= 2) ? 7'h7F : 7'h08;
      digit_check(3'd0, exp0, 1'b1, 1'b1);
      run_range(24, 1, 7, 1'b0);
    end

    // Out-of-order 7->3->0 must not count as a frame boundary
    digit_check(3'd3, 7'h40, 1'b1, 1'b0);
    exp0 = (fc >= 2) ? 7'h7F : 7'h08;
    digit_check(3'd0, exp0, 1'b1, 1'b0);

    // Async reset with pending data and lit glyphs
    digit_check(3'd1, 7'h40, 1'b1, 1'b0);
    set_write(32'h1111_1111, 8'hFF, 8'h00, 8'h00);
    step(1'b0);
    check("lit_before_reset", cathode, 7'h40);
    wif.wr_valid = 1'b0;
    #3;
    reset = 1'b1;
    #1;
    check("async_reset_cathode", cathode, 7'h7F);
    check("async_reset_dp_n", dp_n, 1'b1);
    check("async_reset_wr_ready", wif.wr_ready, 1'b1);
    pend_b = 1'b0;
    exp_ready = 1'b1;
    fc = 0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    run_range(0, 0, 7, 1'b0);
    run_range(0, 0, 7, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
